// File: rtl/sdram_bank_scheduler.sv
// DDR4 bookkeeping core: address decode, per-bank open/busy tracking, timed completion FIFO.
// Optional SDRAM_SCHED_TRACE_EN adds simulation-only command/drop tracing.

module sdram_bank_fsm #(
  parameter int ROW_BITS           = 8,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                activate_in,
  input  logic                precharge_in,
  input  logic [ROW_BITS-1:0] row_address_in,
  output logic [ROW_BITS-1:0] active_row_out,
  output logic                ready_out,
  output logic                active_out,
  output logic                blocked_out,
  output logic                act_ok_out,
  output logic                pre_ok_out
);
  localparam int LAT_MAX = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ? ACTIVATION_LATENCY
                                                                     : PRECHARGE_LATENCY;
  localparam int CW = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACTIVATING, ACTIVE, PRECHARGING} bank_state_e;

  bank_state_e         state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ROW_BITS-1:0] row_q, row_d;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  // Countdown is loaded with latency-1 so the state flips exactly latency edges after the command.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    act_ok_out = 1'b0;
    pre_ok_out = 1'b0;
    case (state_q)
      IDLE: if (activate_in) begin
        state_d    = ACTIVATING;
        cnt_d      = CW'(ACTIVATION_LATENCY - 1);
        row_d      = row_address_in;
        act_ok_out = 1'b1;
      end
      ACTIVATING: if (cnt_q == '0) state_d = ACTIVE;
                  else cnt_d = cnt_q - CW'(1);
      ACTIVE: if (precharge_in) begin
        state_d    = PRECHARGING;
        cnt_d      = CW'(PRECHARGE_LATENCY - 1);
        pre_ok_out = 1'b1;
      end
      PRECHARGING: if (cnt_q == '0) state_d = IDLE;
                   else cnt_d = cnt_q - CW'(1);
      default: state_d = IDLE;
    endcase
  end

  assign active_row_out = row_q;
  assign ready_out      = (state_q == IDLE);
  assign active_out     = (state_q == ACTIVE);
  assign blocked_out    = (state_q == ACTIVATING) || (state_q == PRECHARGING);
endmodule

module sdram_bank_scheduler #(
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int PADDR_BITS         = 19,
  parameter int BANK_GROUPS        = 4,
  parameter int BANKS_PER_GROUP    = 4,
  parameter int BANKS              = BANK_GROUPS * BANKS_PER_GROUP,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int QUEUE_SIZE         = 32,
  parameter int CNT_BITS           = 32
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [PADDR_BITS-1:0]              addr_in,
  output logic                               we_out,
  output logic [COL_BITS-1:0]                col_out,
  output logic [$clog2(BANKS_PER_GROUP)-1:0] ba_out,
  output logic [$clog2(BANK_GROUPS)-1:0]     bg_out,
  output logic [ROW_BITS-1:0]                row_out,
  output logic [$clog2(BANKS)-1:0]           bank_idx_out,
  input  logic [BANKS-1:0]                   activate_in,
  input  logic [BANKS-1:0]                   precharge_in,
  input  logic [ROW_BITS-1:0]                row_address_in,
  output logic [BANKS*ROW_BITS-1:0]          active_row_out,
  output logic [BANKS-1:0]                   ready_to_access_out,
  output logic [BANKS-1:0]                   active_bank_out,
  output logic [BANKS-1:0]                   blocked_out,
  input  logic                               enqueue_in,
  input  logic                               dequeue_in,
  input  logic                               req_read_in,
  input  logic [CNT_BITS-1:0]                req_cycle_in,
  input  logic [CNT_BITS-1:0]                cycle_count_in,
  output logic                               req_read_out,
  output logic [CNT_BITS-1:0]                req_cycle_out,
  output logic                               req_due_out,
  output logic                               empty_out,
  output logic                               full_out
);
  localparam int BA_W  = $clog2(BANKS_PER_GROUP);
  localparam int BG_W  = $clog2(BANK_GROUPS);
  localparam int BI_W  = $clog2(BANKS);
  localparam int TOP_U = COL_BITS + BA_W + BG_W + ROW_BITS;
  localparam int QW    = $clog2(QUEUE_SIZE);

  typedef struct packed {
    logic                rd;
    logic [CNT_BITS-1:0] cyc;
  } rec_t;

  // Address decode
  assign we_out       = addr_in[PADDR_BITS-1];
  assign col_out      = addr_in[COL_BITS-1:0];
  assign ba_out       = addr_in[COL_BITS +: BA_W];
  assign bg_out       = addr_in[COL_BITS+BA_W +: BG_W];
  assign row_out      = addr_in[COL_BITS+BA_W+BG_W +: ROW_BITS];
  assign bank_idx_out = BI_W'(BI_W'(bg_out) * BI_W'(BANKS_PER_GROUP) + BI_W'(ba_out));

  logic unused_addr;
  assign unused_addr = ^addr_in[PADDR_BITS-2:TOP_U];

  // Bank lanes
  logic [BANKS-1:0][ROW_BITS-1:0] row_w;
  logic [BANKS-1:0]               act_ok, pre_ok;

  for (genvar i = 0; i < BANKS; i++) begin : g_bank
    sdram_bank_fsm #(
      .ROW_BITS(ROW_BITS), .ACTIVATION_LATENCY(ACTIVATION_LATENCY),
      .PRECHARGE_LATENCY(PRECHARGE_LATENCY)
    ) u_bank (
      .clk_in(clk_in), .rst_in(rst_in),
      .activate_in(activate_in[i]), .precharge_in(precharge_in[i]),
      .row_address_in(row_address_in), .active_row_out(row_w[i]),
      .ready_out(ready_to_access_out[i]), .active_out(active_bank_out[i]),
      .blocked_out(blocked_out[i]), .act_ok_out(act_ok[i]), .pre_ok_out(pre_ok[i])
    );
  end
  assign active_row_out = row_w;

  // Completion FIFO; pointers wrap for free because depth is a power of two.
  rec_t          mem_q [QUEUE_SIZE];
  logic [QW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QW:0]   count_q, count_d;
  logic          do_enq, do_deq;
  rec_t          head;

  assign empty_out = (count_q == '0);
  assign full_out  = (count_q == (QW+1)'(QUEUE_SIZE));

  always_comb begin
    do_deq   = dequeue_in && !empty_out;
    do_enq   = enqueue_in && (!full_out || do_deq);
    wr_ptr_d = do_enq ? wr_ptr_q + QW'(1) : wr_ptr_q;
    rd_ptr_d = do_deq ? rd_ptr_q + QW'(1) : rd_ptr_q;
    count_d  = count_q + (QW+1)'(do_enq) - (QW+1)'(do_deq);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_enq) mem_q[wr_ptr_q] <= '{rd: req_read_in, cyc: req_cycle_in};
  end

  assign head          = mem_q[rd_ptr_q];
  assign req_read_out  = !empty_out && head.rd;
  assign req_cycle_out = empty_out ? '0 : head.cyc;
  assign req_due_out   = !empty_out && (req_cycle_out < cycle_count_in);

`ifdef SDRAM_SCHED_TRACE_EN
  always @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < BANKS; i++) begin
        if (act_ok[i]) $display("sched: activate bank %0d row %0h", i, row_address_in);
        if (pre_ok[i]) $display("sched: precharge bank %0d row %0h", i, row_w[i]);
      end
      if (enqueue_in && !do_enq) $display("sched: enqueue dropped, queue full");
    end
  end
`else
  logic unused_trace;
  assign unused_trace = ^{act_ok, pre_ok};
`endif
endmodule

// File: tb/tb_sdram_bank_scheduler.sv
// Bench for sdram_bank_scheduler: directed + random stimulus against a timestamp-based bank model
// and a queue-based FIFO model.
module tb_sdram_bank_scheduler;
  localparam int NB = 16, QS = 32, AL = 8, PL = 5;

  logic         clk_in = 1'b0, rst_in;
  logic [18:0]  addr_in;
  logic         we_out;
  logic [3:0]   col_out;
  logic [1:0]   ba_out, bg_out;
  logic [7:0]   row_out;
  logic [3:0]   bank_idx_out;
  logic [15:0]  activate_in, precharge_in;
  logic [7:0]   row_address_in;
  logic [127:0] active_row_out;
  logic [15:0]  ready_to_access_out, active_bank_out, blocked_out;
  logic         enqueue_in, dequeue_in, req_read_in;
  logic [31:0]  req_cycle_in, cycle_count_in, req_cycle_out;
  logic         req_read_out, req_due_out, empty_out, full_out;

  sdram_bank_scheduler dut (
    .clk_in(clk_in), .rst_in(rst_in), .addr_in(addr_in), .we_out(we_out), .col_out(col_out),
    .ba_out(ba_out), .bg_out(bg_out), .row_out(row_out), .bank_idx_out(bank_idx_out),
    .activate_in(activate_in), .precharge_in(precharge_in), .row_address_in(row_address_in),
    .active_row_out(active_row_out), .ready_to_access_out(ready_to_access_out),
    .active_bank_out(active_bank_out), .blocked_out(blocked_out),
    .enqueue_in(enqueue_in), .dequeue_in(dequeue_in), .req_read_in(req_read_in),
    .req_cycle_in(req_cycle_in), .cycle_count_in(cycle_count_in),
    .req_read_out(req_read_out), .req_cycle_out(req_cycle_out), .req_due_out(req_due_out),
    .empty_out(empty_out), .full_out(full_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0, fails = 0;
  int e = 0;                 // edge index since last model reset
  int last_cmd [NB];         // 0 none, 1 activate, 2 precharge
  int t_cmd    [NB];
  logic [7:0] mrow [NB];
  typedef struct { logic rd; logic [31:0] cyc; } rec_t;
  rec_t q[$];

  // 0 idle, 1 blocked, 2 active -- derived from the last accepted command and elapsed edges
  function automatic int bstate(int b, int at);
    if (last_cmd[b] == 1) return (at < t_cmd[b] + AL) ? 1 : 2;
    if (last_cmd[b] == 2) return (at < t_cmd[b] + PL) ? 1 : 0;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin last_cmd[b] = 0; t_cmd[b] = 0; mrow[b] = 8'h0; end
    q.delete();
  endtask

  task automatic check_all();
    logic [15:0] xr, xa, xb; logic [127:0] xrow;
    for (int b = 0; b < NB; b++) begin
      int s = bstate(b, e);
      xr[b] = (s == 0); xb[b] = (s == 1); xa[b] = (s == 2);
      xrow[b*8 +: 8] = mrow[b];
    end
    chk($sformatf("ready@%0d", e), ready_to_access_out, xr);
    chk($sformatf("active@%0d", e), active_bank_out, xa);
    chk($sformatf("blocked@%0d", e), blocked_out, xb);
    chk($sformatf("rows@%0d", e), active_row_out, xrow);
    chk($sformatf("empty@%0d", e), empty_out, q.size() == 0);
    chk($sformatf("full@%0d", e), full_out, q.size() == QS);
    chk($sformatf("hrd@%0d", e), req_read_out, q.size() ? q[0].rd : 1'b0);
    chk($sformatf("hcyc@%0d", e), req_cycle_out, q.size() ? q[0].cyc : 32'h0);
    chk($sformatf("due@%0d", e), req_due_out, q.size() ? (q[0].cyc < cycle_count_in) : 1'b0);
  endtask

  task automatic tick();
    bit dq, eq;
    @(posedge clk_in);
    e++;
    for (int b = 0; b < NB; b++) begin
      int s = bstate(b, e - 1);
      if (s == 0 && activate_in[b]) begin last_cmd[b] = 1; t_cmd[b] = e; mrow[b] = row_address_in; end
      else if (s == 2 && precharge_in[b]) begin last_cmd[b] = 2; t_cmd[b] = e; end
    end
    dq = dequeue_in && q.size() > 0;
    eq = enqueue_in && (q.size() < QS || dq);
    if (dq) void'(q.pop_front());
    if (eq) q.push_back('{rd: req_read_in, cyc: req_cycle_in});
    #1;
    check_all();
  endtask

  initial begin
    int a;
    rst_in = 1'b1; addr_in = '0; activate_in = '0; precharge_in = '0; row_address_in = '0;
    enqueue_in = 0; dequeue_in = 0; req_read_in = 0; req_cycle_in = '0; cycle_count_in = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_all();
    rst_in = 1'b0;

    // Decode
    addr_in = 19'h45A36; #1;
    chk("dec_we", we_out, 1'b1);   chk("dec_col", col_out, 4'd6); chk("dec_ba", ba_out, 2'd3);
    chk("dec_bg", bg_out, 2'd0);   chk("dec_row", row_out, 8'h5A); chk("dec_idx", bank_idx_out, 4'd3);
    addr_in = 19'h00090; #1;
    chk("dec_idx9", bank_idx_out, 4'd9);
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(0, (1 << 19) - 1);
      addr_in = 19'(a); #1;
      chk("rdec_we", we_out, (a >> 18) & 1);
      chk("rdec_col", col_out, a % 16);
      chk("rdec_row", row_out, (a / 256) % 256);
      chk("rdec_idx", bank_idx_out, ((a / 64) % 4) * 4 + (a / 16) % 4);
    end

    // Activate bank 5, re-activate during activation and once open
    activate_in = 16'h0020; row_address_in = 8'h33; tick();
    activate_in = '0; repeat (3) tick();
    activate_in = 16'h0020; row_address_in = 8'h77; tick();
    activate_in = '0; repeat (6) tick();
    chk("act5_open", active_bank_out[5], 1'b1);
    chk("act5_row", active_row_out[47:40], 8'h33);
    activate_in = 16'h0020; row_address_in = 8'h99; tick();
    activate_in = '0;

    // Precharge bank 5 (open) and bank 2 (idle)
    precharge_in = 16'h0024; tick();
    precharge_in = '0; repeat (6) tick();
    chk("pre5_ready", ready_to_access_out[5], 1'b1);
    chk("pre5_row_kept", active_row_out[47:40], 8'h33);

    // FIFO fill to full plus one dropped, then drain in order
    enqueue_in = 1;
    for (int i = 0; i < QS + 1; i++) begin
      req_read_in = 1'($urandom); req_cycle_in = $urandom; tick();
    end
    enqueue_in = 0;
    chk("fill_full", full_out, 1'b1);
    dequeue_in = 1; repeat (QS) tick();
    dequeue_in = 0;
    chk("drain_empty", empty_out, 1'b1);

    // Due flag boundary
    enqueue_in = 1; req_read_in = 1; req_cycle_in = 32'd10; tick();
    enqueue_in = 0;
    cycle_count_in = 32'd10; #1; chk("due_eq", req_due_out, 1'b0);
    cycle_count_in = 32'd11; #1; chk("due_gt", req_due_out, 1'b1);
    dequeue_in = 1; tick(); dequeue_in = 0;

    // Simultaneous enqueue+dequeue when full
    enqueue_in = 1;
    for (int i = 0; i < QS; i++) begin req_cycle_in = $urandom; tick(); end
    dequeue_in = 1; req_cycle_in = 32'hABCD; tick();
    chk("full_swap", full_out, 1'b1);
    enqueue_in = 0; repeat (QS + 2) tick();
    dequeue_in = 0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      activate_in    = 16'($urandom & $urandom & $urandom);
      precharge_in   = 16'($urandom & $urandom);
      row_address_in = 8'($urandom);
      enqueue_in     = 1'($urandom_range(0, 1));
      dequeue_in     = 1'($urandom_range(0, 1));
      req_read_in    = 1'($urandom);
      req_cycle_in   = $urandom_range(0, 63);
      cycle_count_in = $urandom_range(0, 63);
      tick();
    end

    // Quiesce all banks, drain FIFO
    activate_in = '0; enqueue_in = 0; precharge_in = '1; dequeue_in = 1;
    repeat (40) tick();
    precharge_in = '0; dequeue_in = 0;
    chk("quiet_ready", ready_to_access_out, 16'hFFFF);

    // Reset mid-activation with three queued records
    activate_in = 16'h0008; row_address_in = 8'h5C; tick();
    activate_in = '0; enqueue_in = 1;
    for (int i = 0; i < 3; i++) begin req_cycle_in = 32'(i + 1); tick(); end
    enqueue_in = 0;
    chk("pre_rst_blocked", blocked_out[3], 1'b1);
    #2 rst_in = 1'b1; #1;
    model_reset();
    check_all();
    chk("rst_ready", ready_to_access_out, 16'hFFFF);
    chk("rst_empty", empty_out, 1'b1);
    @(posedge clk_in); #1 rst_in = 1'b0;
    e = 0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/sdram_bank_scheduler.md
# sdram_bank_scheduler

Bookkeeping core for the DDR4 SDRAM controller. It bundles three functions:
- Decodes a physical address into write-flag, row, column, bank group, bank and flat bank index.
- Tracks per-bank open/closed/busy state with activation and precharge latencies.
- Holds a FIFO of timed completion records that the controller retires once their due cycle has passed.

It sits between the LLC-facing bus logic and the DIMM command/data pins.

## Interface
Parameters:
- ROW_BITS, 8, row address width
- COL_BITS, 4, column address width
- PADDR_BITS, 19, physical address width
- BANK_GROUPS, 4, bank groups
- BANKS_PER_GROUP, 4, banks per group
- BANKS, BANK_GROUPS*BANKS_PER_GROUP, total banks
- ACTIVATION_LATENCY, 8, cycles a bank is blocked after activate
- PRECHARGE_LATENCY, 5, cycles a bank is blocked after precharge
- QUEUE_SIZE, 32, FIFO depth (power of two)
- CNT_BITS, 32, cycle-stamp width

Ports:
- clk_in  in  1  clock; all state changes on rising edge
- rst_in  in  1  asynchronous, active-high reset
- addr_in  in  PADDR_BITS  physical address
- we_out  out  1  addr_in[PADDR_BITS-1]
- col_out  out  COL_BITS  addr_in[COL_BITS-1:0]
- ba_out  out  log2(BANKS_PER_GROUP)  next field above col
- bg_out  out  log2(BANK_GROUPS)  next field above ba
- row_out  out  ROW_BITS  next field above bg
- bank_idx_out  out  log2(BANKS)  bg*BANKS_PER_GROUP+ba
- activate_in  in  BANKS  per-bank activate request
- precharge_in  in  BANKS  per-bank precharge request
- row_address_in  in  ROW_BITS  row latched by any accepted activate
- active_row_out  out  BANKS*ROW_BITS  open row per bank; bank i at [i*ROW_BITS +: ROW_BITS]
- ready_to_access_out  out  BANKS  bank idle (precharged)
- active_bank_out  out  BANKS  bank has an open row
- blocked_out  out  BANKS  bank activating or precharging
- enqueue_in  in  1  push record
- dequeue_in  in  1  pop head
- req_read_in  in  1  record: read flag
- req_cycle_in  in  CNT_BITS  record: due cycle stamp
- cycle_count_in  in  CNT_BITS  controller's free-running cycle counter
- req_read_out  out  1  head read flag
- req_cycle_out  out  CNT_BITS  head due stamp
- req_due_out  out  1  !empty && req_cycle_out < cycle_count_in
- empty_out  out  1  FIFO empty
- full_out  out  1  FIFO holds QUEUE_SIZE entries

## Operation
- **Address decode:** purely combinational. Bits between the top of row and the we bit are ignored.
- **Bank FSM states:** IDLE, ACTIVATING, ACTIVE, PRECHARGING.
- **Bank transitions:**
  - IDLE + activate_in[i]: go to ACTIVATING and latch row_address_in.
  - ACTIVATING: go to ACTIVE after ACTIVATION_LATENCY cycles.
  - ACTIVE + precharge_in[i]: go to PRECHARGING.
  - PRECHARGING: go to IDLE after PRECHARGE_LATENCY cycles.
- **Ignored requests:**
  - Activate is ignored in any state other than IDLE.
  - Precharge is ignored in any state other than ACTIVE.
  - If both are asserted in the same cycle, only the one legal for the current state takes effect.
- **Bank outputs:**
  - ready_to_access = IDLE.
  - active_bank = ACTIVE.
  - blocked = ACTIVATING or PRECHARGING.
  - active_row_out holds the last latched row. It keeps that value through PRECHARGING and IDLE, and is zero after reset.
- **FIFO:** circular buffer.
  - Enqueue when full is dropped, unless dequeue is asserted in the same cycle; then both happen.
  - Dequeue when empty is ignored.
  - When empty, req_read_out=0, req_cycle_out=0 and req_due_out=0.

## Timing
- Reset (async) values:
  - All banks IDLE; active_row_out=0.
  - ready_to_access_out all ones; active_bank_out and blocked_out all zero.
  - FIFO empty: empty_out=1, full_out=0, head outputs 0.
- Activate sampled at edge T: blocked_out=1 from T through T+ACTIVATION_LATENCY-1, and active_bank_out=1 from edge T+ACTIVATION_LATENCY.
- Precharge timing is the same pattern with PRECHARGE_LATENCY.
- FIFO head outputs and flags update on the edge that enqueues or dequeues. Enqueue into an empty FIFO is visible on req_*_out after that edge.
- req_due_out is combinational from the head and cycle_count_in. Comparison is unsigned, with no wrap handling.
- Reset asserted mid-latency aborts every countdown and empties the FIFO immediately.

## Configuration
- **SDRAM_SCHED_TRACE_EN defined:** simulation $display on each accepted activate/precharge (bank, row) and each dropped enqueue.
- **Not defined:** no display statements.
- RTL behaviour is identical either way.

## Test plan
- **Decode:** addr_in=19'h4_5A36 -> we=1, col=6, ba=3, bg=0, row=8'h5A, bank_idx=3. addr_in with bg=2, ba=1 -> bank_idx=9.
- **Activate:** activate_in[5]=1 with row 8'h33 -> blocked[5] high for 8 cycles, then active_bank[5]=1 and active_row_out bank5=8'h33. A second activate on bank 5 is ignored.
- **Precharge:** precharge on ACTIVE bank 5 -> blocked for 5 cycles, then ready_to_access[5]=1. A precharge on an IDLE bank produces no change.
- **FIFO fill:** enqueue 32 records -> full_out=1 and the 33rd is dropped. Dequeue 32 -> records return in order, then empty_out=1.
- **Due flag:** enqueue stamp 10 -> req_due_out=0 at cycle_count 10 and 1 at 11. Simultaneous enqueue+dequeue when full keeps count at 32.
- **Reset mid-operation:** rst_in pulsed during activation with 3 queued records -> all banks IDLE and FIFO empty immediately.
